// File: rtl/axi_tdd_ng_multiwin_channel.sv
// TDD channel gate with NUM_WIN on/off windows per frame, a frame decimator and a registered polarity output.
// Define AXI_TDD_NG_CH_PULSE_CNT_EN to add the saturating pulse_count output.

package axi_tdd_ng_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;
endpackage

module axi_tdd_ng_multiwin_channel
    import axi_tdd_ng_pkg::*;
#(
    parameter logic DEFAULT_POLARITY = 1'b0,
    parameter int   REGISTER_WIDTH   = 32,
    parameter int   NUM_WIN          = 4,
    parameter int   FDIV_WIDTH       = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [REGISTER_WIDTH-1:0]         tdd_counter,
    input  state_t                            tdd_cstate,
    input  logic                              tdd_enable,
    input  logic                              tdd_endof_frame,
    input  logic                              ch_en,
    input  logic                              ch_pol,
    input  logic [NUM_WIN-1:0]                win_en,
    input  logic [NUM_WIN*REGISTER_WIDTH-1:0] t_high,
    input  logic [NUM_WIN*REGISTER_WIDTH-1:0] t_low,
    input  logic [FDIV_WIDTH-1:0]             frame_div,
    output logic                              out,
    output logic                              frame_active
`ifdef AXI_TDD_NG_CH_PULSE_CNT_EN
    ,
    output logic [31:0]                       pulse_count
`endif
);

    logic                  tdd_ch_en_q, tdd_ch_en_d;
    logic [NUM_WIN-1:0]    win_en_q, win_en_d;
    logic [FDIV_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                  frame_active_q, frame_active_d;
    logic                  tdd_ch_set_q, tdd_ch_set_d;
    logic                  tdd_ch_rst_q, tdd_ch_rst_d;
    logic                  out_q, out_d;
    logic                  ch_act_s;
    logic                  last_frame_s;

    // Config shadow: mid-frame changes only land on a frame boundary
    always_comb begin
        tdd_ch_en_d = tdd_ch_en_q;
        win_en_d    = win_en_q;
        case (tdd_cstate)
            IDLE: begin
                tdd_ch_en_d = 1'b0;
                win_en_d    = {NUM_WIN{1'b0}};
            end
            ARMED: begin
                tdd_ch_en_d = ch_en;
                win_en_d    = win_en;
            end
            default: begin
                if (tdd_endof_frame) begin
                    tdd_ch_en_d = ch_en;
                    win_en_d    = win_en;
                end else begin
                    tdd_ch_en_d = tdd_ch_en_q;
                    win_en_d    = win_en_q;
                end
            end
        endcase
    end

    // Frame decimator; frame_active is precomputed so it is valid on the first cycle of a frame
    always_comb begin
        last_frame_s = (frame_div <= FDIV_WIDTH'(1)) ||
                       (frame_cnt_q == (frame_div - FDIV_WIDTH'(1)));
        frame_cnt_d  = frame_cnt_q;
        if ((tdd_cstate == IDLE) || (tdd_cstate == ARMED)) begin
            frame_cnt_d = {FDIV_WIDTH{1'b0}};
        end else if (tdd_endof_frame) begin
            frame_cnt_d = last_frame_s ? {FDIV_WIDTH{1'b0}} : (frame_cnt_q + FDIV_WIDTH'(1));
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        frame_active_d = (frame_cnt_d == {FDIV_WIDTH{1'b0}});
    end

    // Stage 1: per-window threshold compare merged across windows
    always_comb begin
        tdd_ch_set_d = 1'b0;
        tdd_ch_rst_d = tdd_endof_frame;
        for (int i = 0; i < NUM_WIN; i++) begin
            tdd_ch_set_d = tdd_ch_set_d | ((tdd_cstate == RUNNING) & win_en_q[i] &
                           (tdd_counter == t_high[i*REGISTER_WIDTH +: REGISTER_WIDTH]));
            tdd_ch_rst_d = tdd_ch_rst_d | ((tdd_cstate == RUNNING) & win_en_q[i] &
                           (tdd_counter == t_low[i*REGISTER_WIDTH +: REGISTER_WIDTH]));
        end
    end

    // Stage 2: reset beats set, so t_high==t_low never produces a pulse
    always_comb begin
        ch_act_s = tdd_ch_en_q & frame_active_q;
        if (!ch_act_s || tdd_ch_rst_q) begin
            out_d = ch_pol;
        end else if (tdd_ch_set_q) begin
            out_d = ~ch_pol;
        end else begin
            out_d = out_q;
        end
    end

    // State registers, frozen while tdd_enable is low
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tdd_ch_en_q    <= 1'b0;
            win_en_q       <= {NUM_WIN{1'b0}};
            frame_cnt_q    <= {FDIV_WIDTH{1'b0}};
            frame_active_q <= 1'b0;
            tdd_ch_set_q   <= 1'b0;
            tdd_ch_rst_q   <= 1'b0;
            out_q          <= DEFAULT_POLARITY;
        end else if (tdd_enable) begin
            tdd_ch_en_q    <= tdd_ch_en_d;
            win_en_q       <= win_en_d;
            frame_cnt_q    <= frame_cnt_d;
            frame_active_q <= frame_active_d;
            tdd_ch_set_q   <= tdd_ch_set_d;
            tdd_ch_rst_q   <= tdd_ch_rst_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign frame_active = frame_active_q;

`ifdef AXI_TDD_NG_CH_PULSE_CNT_EN
    logic [31:0] pulse_cnt_q, pulse_cnt_d;

    // Count idle-to-active transitions of out, saturating
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (tdd_cstate == ARMED) begin
            pulse_cnt_d = 32'd0;
        end else if ((out_q == ch_pol) && (out_d == ~ch_pol) && (pulse_cnt_q != 32'hFFFF_FFFF)) begin
            pulse_cnt_d = pulse_cnt_q + 32'd1;
        end else begin
            pulse_cnt_d = pulse_cnt_q;
        end
    end

    // Pulse counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pulse_cnt_q <= 32'd0;
        end else if (tdd_enable) begin
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign pulse_count = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_axi_tdd_ng_multiwin_channel.sv
// Directed bench for axi_tdd_ng_multiwin_channel: 100-cycle frames, windows, decimation, stalls, resets.
module tb_axi_tdd_ng_multiwin_channel;
    import axi_tdd_ng_pkg::*;

    localparam int RW = 32;
    localparam int NW = 4;
    localparam int FW = 8;

    logic           clk;
    logic           resetn;
    logic [RW-1:0]  tdd_counter;
    state_t         tdd_cstate;
    logic           tdd_enable;
    logic           tdd_endof_frame;
    logic           ch_en;
    logic           ch_pol;
    logic [NW-1:0]  win_en;
    logic [NW*RW-1:0] t_high;
    logic [NW*RW-1:0] t_low;
    logic [FW-1:0]  frame_div;
    logic           out;
    logic           frame_active;
`ifdef AXI_TDD_NG_CH_PULSE_CNT_EN
    logic [31:0]    pulse_count;
`endif

    int             n_checks;
    int             n_fails;
    logic           nxt_ch_en;
    logic [NW-1:0]  nxt_win_en;

    axi_tdd_ng_multiwin_channel #(
        .DEFAULT_POLARITY(1'b1),
        .REGISTER_WIDTH  (RW),
        .NUM_WIN         (NW),
        .FDIV_WIDTH      (FW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .tdd_counter    (tdd_counter),
        .tdd_cstate     (tdd_cstate),
        .tdd_enable     (tdd_enable),
        .tdd_endof_frame(tdd_endof_frame),
        .ch_en          (ch_en),
        .ch_pol         (ch_pol),
        .win_en         (win_en),
        .t_high         (t_high),
        .t_low          (t_low),
        .frame_div      (frame_div),
        .out            (out),
        .frame_active   (frame_active)
`ifdef AXI_TDD_NG_CH_PULSE_CNT_EN
        ,
        .pulse_count    (pulse_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_win(input int i, input int hi, input int lo);
        t_high[i*RW +: RW] = 32'(hi);
        t_low[i*RW +: RW]  = 32'(lo);
    endtask

    // IDLE for two cycles (out must settle to pol), then ARMED with new config
    task automatic arm(input logic pol, input logic en, input logic [NW-1:0] we, input logic [FW-1:0] div);
        tdd_cstate      = IDLE;
        tdd_endof_frame = 1'b0;
        tdd_counter     = 32'd0;
        ch_pol          = pol;
        step();
        step();
        check_eq("idle_out", {31'd0, out}, {31'd0, pol});
        ch_en      = en;
        win_en     = we;
        frame_div  = div;
        tdd_cstate = ARMED;
        step();
        step();
        tdd_cstate = RUNNING;
    endtask

    // One 100-cycle frame; out expected active inside [lo1,hi1] or [lo2,hi2]
    task automatic run_frame(input string nm, input int lo1, input int hi1, input int lo2, input int hi2,
                             input logic exp_fa, input int chg_at, input int stall_at, input int last);
        logic exp_o;
        for (int c = 0; c <= last; c++) begin
            tdd_counter     = 32'(c);
            tdd_endof_frame = (c == 99);
            if (c == chg_at) begin
                ch_en  = nxt_ch_en;
                win_en = nxt_win_en;
            end
            exp_o = ((c >= lo1 && c <= hi1) || (c >= lo2 && c <= hi2)) ? ~ch_pol : ch_pol;
            check_eq($sformatf("%s_out_c%0d", nm, c), {31'd0, out}, {31'd0, exp_o});
            check_eq($sformatf("%s_fa_c%0d", nm, c), {31'd0, frame_active}, {31'd0, exp_fa});
            if (c == stall_at) begin
                tdd_enable = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check_eq($sformatf("%s_stall%0d", nm, s), {31'd0, out}, {31'd0, exp_o});
                end
                tdd_enable = 1'b1;
            end
            if (c != last || last == 99) step();
        end
        tdd_endof_frame = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        resetn          = 1'b0;
        tdd_enable      = 1'b1;
        tdd_cstate      = IDLE;
        tdd_counter     = 32'd0;
        tdd_endof_frame = 1'b0;
        ch_en           = 1'b0;
        ch_pol          = 1'b0;
        win_en          = 4'b0000;
        t_high          = {(NW*RW){1'b0}};
        t_low           = {(NW*RW){1'b0}};
        frame_div       = 8'd1;
        nxt_ch_en       = 1'b0;
        nxt_win_en      = 4'b0000;
        step();
        step();
        step();
        check_eq("reset_out", {31'd0, out}, 32'd1);
        check_eq("reset_fa", {31'd0, frame_active}, 32'd0);
        resetn = 1'b1;

        // Two windows, disabled windows 2/3 carry thresholds that must be ignored
        set_win(0, 10, 20);
        set_win(1, 40, 50);
        set_win(2, 5, 95);
        set_win(3, 60, 70);
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("a0", 12, 21, 42, 51, 1'b1, -1, -1, 99);
        run_frame("a1", 12, 21, 42, 51, 1'b1, -1, -1, 99);

        // Overlap merges: set at 10, first reset at 30
        set_win(0, 10, 30);
        set_win(1, 20, 40);
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("b", 12, 31, -1, -1, 1'b1, -1, -1, 99);

        // (15,15) never pulses; (60,55) only ends at end-of-frame
        set_win(2, 15, 15);
        set_win(3, 60, 55);
        arm(1'b0, 1'b1, 4'b1100, 8'd1);
        run_frame("c0", 62, 99, -1, -1, 1'b1, -1, -1, 99);
        run_frame("c1", 0, 0, 62, 99, 1'b1, -1, -1, 99);

        // Decimation by 3, then frame_div=0 means every frame
        set_win(0, 10, 20);
        set_win(1, 40, 50);
        arm(1'b0, 1'b1, 4'b0011, 8'd3);
        for (int f = 0; f < 7; f++) begin
            if (f % 3 == 0) run_frame($sformatf("d%0d", f), 12, 21, 42, 51, 1'b1, -1, -1, 99);
            else            run_frame($sformatf("d%0d", f), -1, -1, -1, -1, 1'b0, -1, -1, 99);
        end
        arm(1'b0, 1'b1, 4'b0011, 8'd0);
        run_frame("z0", 12, 21, 42, 51, 1'b1, -1, -1, 99);
        run_frame("z1", 12, 21, 42, 51, 1'b1, -1, -1, 99);

        // Mid-frame config change lands at the next frame
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("e0", 12, 21, 42, 51, 1'b1, -1, -1, 99);
        run_frame("e1", 12, 21, 42, 51, 1'b1, -1, -1, 99);
        nxt_ch_en  = 1'b0;
        nxt_win_en = 4'b0001;
        run_frame("e2", 12, 21, 42, 51, 1'b1, 30, -1, 99);
        run_frame("e3", -1, -1, -1, -1, 1'b1, -1, -1, 99);

        // Inverted polarity
        arm(1'b1, 1'b1, 4'b0011, 8'd1);
        run_frame("p0", 12, 21, 42, 51, 1'b1, -1, -1, 99);

        // Enable stall inside a pulse keeps alignment
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("f0", 12, 21, 42, 51, 1'b1, -1, 15, 99);

        // Back to IDLE mid-pulse
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("g0", 12, 21, 42, 51, 1'b1, -1, -1, 15);
        tdd_cstate = IDLE;
        step();
        step();
        check_eq("idle_mid_pulse", {31'd0, out}, 32'd0);

        // Reset mid-pulse, with tdd_enable low
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        run_frame("h0", 12, 21, 42, 51, 1'b1, -1, -1, 15);
        resetn     = 1'b0;
        tdd_enable = 1'b0;
        step();
        check_eq("rst_mid_out", {31'd0, out}, 32'd1);
        check_eq("rst_mid_fa", {31'd0, frame_active}, 32'd0);
        resetn     = 1'b1;
        tdd_enable = 1'b1;
        tdd_cstate = IDLE;
        step();
        step();
        check_eq("post_rst_out", {31'd0, out}, 32'd0);

`ifdef AXI_TDD_NG_CH_PULSE_CNT_EN
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        check_eq("pcnt_armed", pulse_count, 32'd0);
        for (int f = 0; f < 10; f++) run_frame($sformatf("k%0d", f), 12, 21, 42, 51, 1'b1, -1, -1, 99);
        check_eq("pcnt_10fr", pulse_count, 32'd20);
        arm(1'b0, 1'b1, 4'b0011, 8'd1);
        check_eq("pcnt_rearm", pulse_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
